l0_feeder: RTL and testbench
============================

L0_FEEDER -- requirements
Module: l0_feeder

Interface
REQ-001 SHALL have parameter row, default 8: number of array rows fed (one lane per row).
REQ-002 SHALL have parameter bw, default 4: activation/weight width per lane.
REQ-003 SHALL have parameter depth, default 64: entries per lane, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, row*bw bits: write vector; lane r is in[r*bw+bw-1 : r*bw].
REQ-007 SHALL have port in_inst, input, 2 bits: instruction stored with the vector; bit1 is execute, bit0 is kernel load.
REQ-008 SHALL have port wr, input, 1 bit: write request.
REQ-009 SHALL have port rd, input, 1 bit: read request; starts one skewed diagonal read.
REQ-010 SHALL have port out, output, row*bw bits: per-lane data, drives the array west inputs.
REQ-011 SHALL have port out_inst, output, row*2 bits: per-lane instruction, drives the array west instruction inputs.
REQ-012 SHALL have port o_full, output, 1 bit: no free entry.
REQ-013 SHALL have port o_ready, output, 1 bit: equals NOT o_full.
REQ-014 SHALL have port o_empty, output, 1 bit: no entry left for lane 0 to start.
REQ-015 SHALL have port o_valid, output, 1 bit: at least one lane presents a fresh entry this cycle.

Function
REQ-016 SHALL store each accepted write as one entry of row lanes plus in_inst, in shared storage with depth entries.
REQ-017 SHALL keep one write pointer and one read pointer per lane, each log2(depth)+1 bits, wrapping modulo 2*depth.
REQ-018 SHALL accept a write only when wr=1 and o_full=0: store the entry at the write pointer and increment it; a write at full is dropped with no state change.
REQ-019 SHALL accept a read only when rd=1 and o_empty=0; a read when empty is dropped.
REQ-020 SHALL hold a row-stage shift register of accepted reads: stage 0 is the accepted read this cycle, and stage r is stage r-1 delayed one cycle.
REQ-021 SHALL, when stage r is 1, register lane r of the entry at lane-r read pointer onto out lane r and its instruction onto out_inst lane r, then increment that read pointer.
REQ-022 SHALL, when stage r is 0, hold the previous out lane r value and drive out_inst lane r to 2'b00 (no-op to the tile).
REQ-023 SHALL give a fixed latency: a read accepted on edge t appears on lane r after edge t+1+r, which produces the diagonal skew.
REQ-024 SHALL compute o_empty combinationally as (lane-0 read pointer == write pointer).
REQ-025 SHALL compute o_full combinationally as (write pointer minus lane-(row-1) read pointer == depth), so the slowest lane frees entries.
REQ-026 SHALL evaluate flags on pre-edge pointers: simultaneous wr and rd at empty gives no fall-through (read dropped, write taken); simultaneous wr at full while lane row-1 reads drops the write.
REQ-027 SHALL never let a lane read an unwritten entry; this is guaranteed by REQ-019 and the stage ordering.
REQ-028 SHALL register o_valid as the OR of all stages in the same edge that updates out.
REQ-029 SHALL pass data unmodified, with no arithmetic on lane values.

Reset
REQ-030 SHALL, on reset=1 and independent of clk, clear all pointers and the stage register and set out=0, out_inst=0, o_valid=0; the resulting flags are o_empty=1, o_full=0, o_ready=1.
REQ-031 SHALL, when reset is asserted mid-read, discard in-flight skewed reads; stored contents are don't-care afterwards.
REQ-032 SHALL ignore wr and rd while reset=1, with normal operation from the first rising edge after release.

Verification
REQ-033 SHALL pass this scenario: row=4, bw=4; write lanes {3,2,1,0}={4,3,2,1}, inst=2'b10; one rd pulse -> lane0=1 after edge t+1, lane1=2 after t+2, lane2=3 after t+3, lane3=4 after t+4, each lane's out_inst=10 for exactly one cycle, otherwise 00.
REQ-034 SHALL pass this scenario: depth=4; five writes with no reads -> o_full=1 after the fourth write, fifth write dropped; four reads return the first four vectors in order.
REQ-035 SHALL pass this scenario: wr and rd together from reset (empty) -> no output activity that cycle, o_empty=0 next cycle, and a later rd returns the written vector.
REQ-036 SHALL pass this scenario: depth=4, full, rd pulse -> o_full stays 1 until lane row-1 has read (row cycles later); a write at that moment is dropped and the next cycle accepted.
REQ-037 SHALL pass this scenario: 10 back-to-back write/read pairs with depth=4 -> pointers wrap correctly and all 10 vectors appear skewed, in order, with no loss.
REQ-038 SHALL pass this scenario: reset asserted two cycles after rd with row=4 -> out, out_inst and o_valid become 0 immediately, and lanes 2 and 3 never emit that entry.

Source files
------------

// File: rtl/l0_feeder.sv
// Skewed L0 feeder: a shared FIFO of row-wide vectors read out diagonally, lane r
// trailing lane 0 by r cycles so a systolic array sees its west inputs aligned. Needs row >= 2.
module l0_feeder #(
   parameter int row   = 8,
   parameter int bw    = 4,
   parameter int depth = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [row*bw-1:0] in,
   input  logic [1:0]        in_inst,
   input  logic              wr,
   input  logic              rd,
   output logic [row*bw-1:0] out,
   output logic [row*2-1:0]  out_inst,
   output logic              o_full,
   output logic              o_ready,
   output logic              o_empty,
   output logic              o_valid
);
   localparam int AW = $clog2(depth);
   localparam int PW = AW + 1;

   logic [row*bw-1:0] r_mem_d [depth];
   logic [1:0]        r_mem_i [depth];
   logic [PW-1:0]     r_wp;
   logic [PW-1:0]     r_rp [row];
   logic [row-1:1]    r_vld_pipe;
   logic [row-1:0]    w_vld_p0;
   logic [PW-1:0]     w_used;
   logic              w_wr_acc;
   logic              w_rd_acc;

   // Flags come from pre-edge pointers; the slowest lane (row-1) decides when an entry is free.
   assign o_empty  = (r_rp[0] == r_wp);
   assign w_used   = r_wp - r_rp[row-1];
   assign o_full   = (w_used == PW'(depth));
   assign o_ready  = ~o_full;
   assign w_wr_acc = wr & ~o_full;
   assign w_rd_acc = rd & ~o_empty;
   assign w_vld_p0 = {r_vld_pipe, w_rd_acc};

   always_ff @(posedge clk) begin
      if (w_wr_acc && !reset) begin
         r_mem_d[r_wp[AW-1:0]] <= in;
         r_mem_i[r_wp[AW-1:0]] <= in_inst;
      end
   end

   // ---- stage boundary: lane r fires when its slot of the skew pipe is set ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp       <= '0;
         r_vld_pipe <= '0;
         o_valid    <= 1'b0;
         out        <= '0;
         out_inst   <= '0;
         for (int r = 0; r < row; r++) begin
            r_rp[r] <= '0;
         end
      end else begin
         if (w_wr_acc) begin
            r_wp <= r_wp + PW'(1);
         end
         r_vld_pipe <= w_vld_p0[row-2:0];
         o_valid    <= |w_vld_p0;
         for (int r = 0; r < row; r++) begin
            if (w_vld_p0[r]) begin
               out[r*bw +: bw]    <= r_mem_d[r_rp[r][AW-1:0]][r*bw +: bw];
               out_inst[r*2 +: 2] <= r_mem_i[r_rp[r][AW-1:0]];
               r_rp[r]            <= r_rp[r] + PW'(1);
            end else begin
               out_inst[r*2 +: 2] <= 2'b00;
            end
         end
      end
   end

endmodule

// File: tb/tb_l0_feeder.sv
// Bench for l0_feeder: a count-based model schedules per-lane expectations into queues
// that a negedge monitor pops; a flag table and short sequences cover the corner cases.
module tb_l0_feeder;
   localparam int ROW   = 4;
   localparam int BW    = 4;
   localparam int DEPTH = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [ROW*BW-1:0]   in = '0;
   logic [1:0]          in_inst = 2'b00;
   logic                wr = 1'b0;
   logic                rd = 1'b0;
   logic [ROW*BW-1:0]   out;
   logic [ROW*2-1:0]    out_inst;
   logic                o_full, o_ready, o_empty, o_valid;

   l0_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset), .in(in), .in_inst(in_inst), .wr(wr), .rd(rd),
      .out(out), .out_inst(out_inst), .o_full(o_full), .o_ready(o_ready),
      .o_empty(o_empty), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int emit3  = 0;

   typedef struct {
      int            edge_n;
      logic [BW-1:0] d;
      logic [1:0]    ins;
   } exp_t;

   typedef struct {
      logic              w;
      logic              r;
      logic [ROW*BW-1:0] d;
      logic [1:0]        ins;
      logic              e_empty;
      logic              e_full;
   } vec_t;

   exp_t              lq [ROW][$];
   logic [ROW*BW+1:0] wq [$];
   int                rdq [$];
   int                nw = 0;
   int                nr = 0;
   logic              wa;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Model: lane 0 pointer counts all earlier reads, lane ROW-1 only those ROW-1 edges old.
   task automatic step(input logic w, input logic r, input logic [ROW*BW-1:0] d,
                       input logic [1:0] ins, output logic wacc);
      int                en;
      int                done_last;
      logic              m_empty, m_full, racc;
      logic [ROW*BW+1:0] v;
      exp_t              e;
      en = cyc + 1;
      done_last = 0;
      foreach (rdq[i]) if (rdq[i] <= en - ROW) done_last++;
      m_empty = (nw == nr);
      m_full  = ((nw - done_last) == DEPTH);
      wacc = w && !m_full;
      racc = r && !m_empty;
      if (racc) begin
         v = wq[nr];
         for (int l = 0; l < ROW; l++) begin
            e.edge_n = en + l;
            e.d      = v[l*BW +: BW];
            e.ins    = v[ROW*BW +: 2];
            lq[l].push_back(e);
         end
         rdq.push_back(en);
         nr++;
      end
      if (wacc) begin
         wq.push_back({ins, d});
         nw++;
      end
      wr = w; rd = r; in = d; in_inst = ins;
      @(posedge clk);
      @(negedge clk);
      #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic flush_model();
      for (int l = 0; l < ROW; l++) lq[l].delete();
      wq.delete();
      rdq.delete();
      nw = 0;
      nr = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr = 1'b0; rd = 1'b0;
      #1;
      flush_model();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic drain();
      int total;
      repeat (ROW + 1) step(1'b0, 1'b0, '0, 2'b00, wa);
      total = 0;
      for (int l = 0; l < ROW; l++) total += lq[l].size();
      chk("scoreboard_drained", 32'(total), 32'd0);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      logic anyv;
      if (!reset) begin
         anyv = 1'b0;
         for (int l = 0; l < ROW; l++) begin
            while (lq[l].size() > 0 && lq[l][0].edge_n < cyc) begin
               chk("lane_emit_time", 32'(cyc), 32'(lq[l][0].edge_n));
               void'(lq[l].pop_front());
            end
            if (lq[l].size() > 0 && lq[l][0].edge_n == cyc) begin
               e = lq[l].pop_front();
               anyv = 1'b1;
               if (l == ROW - 1) emit3++;
               chk("lane_data", 32'(out[l*BW +: BW]), 32'(e.d));
               chk("lane_inst", 32'(out_inst[l*2 +: 2]), 32'(e.ins));
            end else begin
               chk("lane_idle_inst", 32'(out_inst[l*2 +: 2]), 32'd0);
            end
         end
         chk("o_valid", 32'(o_valid), 32'(anyv));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t              tbl [12];
      logic [ROW*BW-1:0] pv [10];
      logic [1:0]        pi [10];
      int                idx;
      int                e3_start;

      tbl[0]  = '{1'b1, 1'b0, 16'hA1B2, 2'b01, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 16'hC3D4, 2'b10, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 16'h5E6F, 2'b11, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 16'h7089, 2'b01, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 16'hFFFF, 2'b10, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0};

      // Asynchronous reset, checked before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_out_inst", 32'(out_inst), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_full", 32'(o_full), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // Single diagonal read of {4,3,2,1}.
      step(1'b1, 1'b0, 16'h4321, 2'b10, wa);
      step(1'b0, 1'b1, '0, 2'b00, wa);
      chk("skew_lane0_data", 32'(out[3:0]), 32'd1);
      chk("skew_lane0_inst", 32'(out_inst[1:0]), 32'd2);
      step(1'b0, 1'b0, '0, 2'b00, wa);
      chk("skew_lane1_data", 32'(out[7:4]), 32'd2);
      chk("skew_lane0_noop", 32'(out_inst[1:0]), 32'd0);
      drain();
      chk("skew_hold_out", 32'(out), 32'h4321);
      chk("skew_hold_inst", 32'(out_inst), 32'd0);

      // Fill past full, then read back.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].ins, wa);
         chk($sformatf("tbl%0d_empty", i), 32'(o_empty), 32'(tbl[i].e_empty));
         chk($sformatf("tbl%0d_full", i), 32'(o_full), 32'(tbl[i].e_full));
         chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(!tbl[i].e_full));
      end
      drain();

      // Write and read together while empty: no fall-through.
      do_reset();
      step(1'b1, 1'b1, 16'h2468, 2'b01, wa);
      chk("wr_rd_empty_valid", 32'(o_valid), 32'd0);
      chk("wr_rd_empty_flag", 32'(o_empty), 32'd0);
      step(1'b0, 1'b1, '0, 2'b00, wa);
      drain();

      // Full release is gated by the last lane.
      do_reset();
      for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 16'(16'h1111 * (k + 1)), 2'b11, wa);
      chk("full_after_fill", 32'(o_full), 32'd1);
      step(1'b0, 1'b1, '0, 2'b00, wa);
      chk("full_t0", 32'(o_full), 32'd1);
      step(1'b0, 1'b0, '0, 2'b00, wa);
      chk("full_t1", 32'(o_full), 32'd1);
      step(1'b0, 1'b0, '0, 2'b00, wa);
      chk("full_t2", 32'(o_full), 32'd1);
      step(1'b1, 1'b0, 16'hBEEF, 2'b10, wa);
      chk("full_release_drop", 32'(o_full), 32'd0);
      step(1'b1, 1'b0, 16'hBEEF, 2'b10, wa);
      chk("full_refill", 32'(o_full), 32'd1);
      repeat (DEPTH) step(1'b0, 1'b1, '0, 2'b00, wa);
      drain();

      // Ten write/read pairs wrapping the pointers.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         pv[k] = 16'($urandom);
         pi[k] = 2'($urandom_range(1, 3));
      end
      e3_start = emit3;
      idx = 0;
      for (int k = 0; k < 60 && idx < 10; k++) begin
         step(1'b1, 1'b1, pv[idx], pi[idx], wa);
         if (wa) idx++;
      end
      for (int k = 0; k < 20 && nr < nw; k++) step(1'b0, 1'b1, '0, 2'b00, wa);
      drain();
      chk("pairs_lane3_count", 32'(emit3 - e3_start), 32'd10);

      // Reset two cycles after a read discards the in-flight lanes.
      do_reset();
      step(1'b1, 1'b0, 16'h9876, 2'b11, wa);
      step(1'b0, 1'b1, '0, 2'b00, wa);
      step(1'b0, 1'b0, '0, 2'b00, wa);
      reset = 1'b1; wr = 1'b1; rd = 1'b1; in = 16'h1234; in_inst = 2'b01;
      #1;
      chk("midrst_out", 32'(out), 32'd0);
      chk("midrst_inst", 32'(out_inst), 32'd0);
      chk("midrst_valid", 32'(o_valid), 32'd0);
      flush_model();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; wr = 1'b0; rd = 1'b0;
      #1;
      repeat (6) step(1'b0, 1'b0, '0, 2'b00, wa);
      chk("midrst_no_emit", 32'(out), 32'd0);
      chk("midrst_wr_ignored", 32'(o_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
